// File: rtl/cnt_mon_pkg.sv
// Shared types and constants for the count_monitor block.
package cnt_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } cnt_state_t;

    localparam int ERR_CNT_W = 8;
    localparam int RUN_W     = 4;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/count_monitor.sv
// Monitors an upstream counter for a +1 sequence and locks after LOCK_N good steps.
// Optional sticky error flag enabled by defining CNT_MON_STICKY_EN.
module count_monitor
    import cnt_mon_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int LOCK_N = 3
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [WIDTH-1:0]     in,
    input  logic                 in_vld,
    output logic                 locked,
    output logic                 wrap,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
`ifdef CNT_MON_STICKY_EN
    output logic                 err_sticky,
`endif
    output cnt_state_t           dbg_state
);

    localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_N);

    cnt_state_t       state;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] prev_inc;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_inc;
    logic             match;
    logic             err_hit;

    assign prev_inc  = prev + 1'b1;
    assign run_inc   = run + 1'b1;
    assign match     = (in == prev_inc);
    assign err_hit   = in_vld && (state == LOCKED) && !match;
    assign dbg_state = state;

    // wrap/err default low so they pulse for exactly the cycle after the sample edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= IDLE;
            prev   <= '0;
            run    <= '0;
            locked <= 1'b0;
            wrap   <= 1'b0;
            err    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            err  <= 1'b0;
            if (in_vld) begin
                prev <= in;
                case (state)
                    IDLE: begin
                        run    <= '0;
                        state  <= TRACK;
                        locked <= 1'b0;
                    end
                    TRACK: begin
                        if (match) begin
                            run <= run_inc;
                            if (run_inc == LOCK_RUN) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            run <= '0;
                        end
                    end
                    LOCKED: begin
                        // A match from all-ones can only be the step to zero.
                        if (match) begin
                            wrap <= &prev;
                        end else begin
                            err    <= 1'b1;
                            run    <= '0;
                            state  <= TRACK;
                            locked <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        run    <= '0;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_cnt #(.W(ERR_CNT_W)) u_err_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .inc   (err_hit),
        .count (err_cnt)
    );

`ifdef CNT_MON_STICKY_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_sticky <= 1'b0;
        end else if (err_hit) begin
            err_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor (WIDTH=4, LOCK_N=3); honours CNT_MON_STICKY_EN.
module tb_count_monitor;
    import cnt_mon_pkg::*;

    logic       clk;
    logic       n_rst;
    logic [3:0] in;
    logic       in_vld;
    logic       locked;
    logic       wrap;
    logic       err;
    logic [7:0] err_cnt;
`ifdef CNT_MON_STICKY_EN
    logic       err_sticky;
`endif
    cnt_state_t dbg_state;

    int checks = 0;
    int errors = 0;

    count_monitor #(.WIDTH(4), .LOCK_N(3)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in        (in),
        .in_vld    (in_vld),
        .locked    (locked),
        .wrap      (wrap),
        .err       (err),
        .err_cnt   (err_cnt),
`ifdef CNT_MON_STICKY_EN
        .err_sticky(err_sticky),
`endif
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed no_finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on the falling edge, then settle just after the sampling edge.
    task automatic step(input logic [3:0] v, input logic vld);
        @(negedge clk);
        in     = v;
        in_vld = vld;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] v;
        int         exp_cnt;

        n_rst  = 1'b0;
        in     = 4'd0;
        in_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        n_rst = 1'b1;

        // Scenario 1: acquire lock on 0,1,2,3
        step(4'd0, 1'b1);
        chk("s1_first_err", 32'(err), 32'd0);
        chk("s1_first_state", 32'(dbg_state), 32'(TRACK));
        step(4'd1, 1'b1);
        chk("s1_locked_1", 32'(locked), 32'd0);
        step(4'd2, 1'b1);
        chk("s1_locked_2", 32'(locked), 32'd0);
        step(4'd3, 1'b1);
        chk("s1_locked_3", 32'(locked), 32'd1);
        chk("s1_err_3", 32'(err), 32'd0);
        chk("s1_state_3", 32'(dbg_state), 32'(LOCKED));

        // Scenario 2: wrap-around 14,15,0 while locked
        for (int i = 4; i <= 14; i++) begin
            step(4'(i), 1'b1);
            chk("s2_pre_err", 32'(err), 32'd0);
            chk("s2_pre_wrap", 32'(wrap), 32'd0);
        end
        step(4'd15, 1'b1);
        chk("s2_wrap_15", 32'(wrap), 32'd0);
        step(4'd0, 1'b1);
        chk("s2_wrap_0", 32'(wrap), 32'd1);
        chk("s2_locked_0", 32'(locked), 32'd1);
        step(4'd1, 1'b1);
        chk("s2_wrap_after", 32'(wrap), 32'd0);

        // Scenario 3: error at 5 -> 7, then re-lock on 8,9,10
        for (int i = 2; i <= 5; i++) step(4'(i), 1'b1);
        chk("s3_locked_5", 32'(locked), 32'd1);
        step(4'd7, 1'b1);
        chk("s3_err", 32'(err), 32'd1);
        chk("s3_err_cnt", 32'(err_cnt), 32'd1);
        chk("s3_unlocked", 32'(locked), 32'd0);
        chk("s3_state", 32'(dbg_state), 32'(TRACK));
        step(4'd8, 1'b1);
        chk("s3_err_pulse_end", 32'(err), 32'd0);
        chk("s3_locked_8", 32'(locked), 32'd0);
        step(4'd9, 1'b1);
        chk("s3_locked_9", 32'(locked), 32'd0);
        step(4'd10, 1'b1);
        chk("s3_locked_10", 32'(locked), 32'd1);
        chk("s3_err_cnt_hold", 32'(err_cnt), 32'd1);

        // Scenario 4: in_vld gaps with garbage on in
        for (int i = 11; i <= 15; i++) step(4'(i), 1'b1);
        for (int i = 0; i <= 3; i++) step(4'(i), 1'b1);
        step(4'd9, 1'b0);
        chk("s4_gap1_err", 32'(err), 32'd0);
        chk("s4_gap1_locked", 32'(locked), 32'd1);
        step(4'd0, 1'b0);
        chk("s4_gap2_err", 32'(err), 32'd0);
        chk("s4_gap2_wrap", 32'(wrap), 32'd0);
        step(4'd4, 1'b1);
        chk("s4_resume_err", 32'(err), 32'd0);
        chk("s4_resume_locked", 32'(locked), 32'd1);
        chk("s4_resume_err_cnt", 32'(err_cnt), 32'd1);

        // Scenario 5: 300 forced errors, each followed by re-lock
        v       = 4'd4;
        exp_cnt = 1;
        for (int n = 0; n < 300; n++) begin
            v = v + 4'd2;
            step(v, 1'b1);
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            chk("s5_err", 32'(err), 32'd1);
            chk("s5_err_cnt", 32'(err_cnt), 32'(exp_cnt));
            for (int k = 0; k < 3; k++) begin
                v = v + 4'd1;
                step(v, 1'b1);
            end
            chk("s5_relock", 32'(locked), 32'd1);
        end
        chk("s5_err_cnt_sat", 32'(err_cnt), 32'd255);
`ifdef CNT_MON_STICKY_EN
        chk("s5_sticky", 32'(err_sticky), 32'd1);
`endif

        // Scenario 6: asynchronous reset while locked
        #1;
        n_rst = 1'b0;
        #1;
        chk("s6_async_locked", 32'(locked), 32'd0);
        chk("s6_async_err_cnt", 32'(err_cnt), 32'd0);
        chk("s6_async_state", 32'(dbg_state), 32'(IDLE));
        chk("s6_async_wrap", 32'(wrap), 32'd0);
        chk("s6_async_err", 32'(err), 32'd0);
`ifdef CNT_MON_STICKY_EN
        chk("s6_async_sticky", 32'(err_sticky), 32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        step(4'd9, 1'b1);
        chk("s6_first_err", 32'(err), 32'd0);
        chk("s6_first_state", 32'(dbg_state), 32'(TRACK));
        step(4'd10, 1'b1);
        step(4'd11, 1'b1);
        chk("s6_locked_11", 32'(locked), 32'd0);
        step(4'd12, 1'b1);
        chk("s6_locked_12", 32'(locked), 32'd1);
        chk("s6_err_cnt", 32'(err_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter WIDTH, default 4, sets the bit width of the monitored counter value.
REQ-002 Parameter LOCK_N, default 3, sets the number of consecutive correct increments required to lock; legal range is 1..15.
REQ-003 Port clk, input, 1 bit: single clock, rising edge.
REQ-004 Port n_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port in, input, WIDTH bits: counter value from the upstream counter stage.
REQ-006 Port in_vld, input, 1 bit: in is sampled only on cycles where in_vld=1.
REQ-007 Port locked, output, 1 bit: the monitor is in state LOCKED.
REQ-008 Port wrap, output, 1 bit: one-cycle pulse when a wrap-around is observed while locked.
REQ-009 Port err, output, 1 bit: one-cycle pulse on a sequence error while locked.
REQ-010 Port err_cnt, output, 8 bits: count of sequence errors, saturating.

Function
REQ-011 The monitor SHALL be a three-state FSM with states IDLE, TRACK and LOCKED.
REQ-012 IDLE: the first valid sample SHALL be stored in prev, clear run, and move to TRACK.
REQ-013 TRACK: a valid sample equal to (prev+1) mod 2^WIDTH SHALL increment run; when run reaches LOCK_N, the FSM SHALL move to LOCKED.
REQ-014 TRACK mismatch: the FSM SHALL stay in TRACK and clear run; err SHALL NOT pulse.
REQ-015 LOCKED mismatch: the FSM SHALL pulse err, increment err_cnt, clear run and move to TRACK.
REQ-016 LOCKED match with prev all-ones and in=0: the FSM SHALL pulse wrap.
REQ-017 On every valid sample in any state, prev SHALL be updated with in.
REQ-018 All outputs SHALL be registered; wrap and err SHALL assert on the clock edge after the sample edge, for exactly 1 cycle.
REQ-019 Cycles with in_vld=0 SHALL leave state, prev, run and all counters unchanged; wrap and err SHALL be 0 on those cycles.
REQ-020 err_cnt SHALL saturate at 255 and SHALL NOT wrap.
REQ-021 Increment arithmetic SHALL be WIDTH-bit modulo.
REQ-022 For WIDTH=1, the legal sequence SHALL be 0,1,0,1,...

Reset
REQ-023 When n_rst=0, the block SHALL immediately force state=IDLE, prev=0, run=0, locked=0, wrap=0, err=0, err_cnt=0.
REQ-024 Reset asserted mid-operation, including while LOCKED, SHALL discard all history; after release, the block SHALL re-acquire from IDLE.
REQ-025 The first valid sample after reset release SHALL NOT produce err.

Configuration
REQ-026 With CNT_MON_STICKY_EN defined, an extra output err_sticky (1 bit) SHALL be present; it is set on the cycle err pulses and cleared only by reset.
REQ-027 Without CNT_MON_STICKY_EN, err_sticky and its flop SHALL be absent; all other behaviour is identical.

Structure
REQ-028 A shared package cnt_mon_pkg SHALL hold the FSM state enum (IDLE, TRACK, LOCKED) and the constant ERR_CNT_W=8.
REQ-029 The 8-bit saturating counter SHALL be the sub-module sat_cnt, parameterised by width.
REQ-030 The run counter SHALL be 4 bits wide.

Verification
REQ-031 Scenario 1: WIDTH=4, in_vld=1, in=0,1,2,3 after reset -> locked=1 one cycle after the sample in=3; err=0 throughout.
REQ-032 Scenario 2: locked, then in=14,15,0 -> wrap pulses exactly once, the cycle after the sample 0; locked stays 1.
REQ-033 Scenario 3: locked at in=5, then in=7 -> err pulses 1 cycle, err_cnt=1, locked=0; then 8,9,10 -> locked=1 again.
REQ-034 Scenario 4: locked, in_vld toggled 1,0,0,1 with in=3,x,x,4 -> no err, state held; garbage on in while in_vld=0 is ignored.
REQ-035 Scenario 5: 300 forced errors, each followed by re-lock -> err_cnt=255 after the 255th error and holds; err_sticky=1 when CNT_MON_STICKY_EN is defined.
REQ-036 Scenario 6: n_rst pulsed low for 2 cycles while locked -> all outputs 0 asynchronously; after release, sequence 9,10,11,12 -> locked=1, err_cnt=0.
